// File: rtl/rf_wb_sched_pkg.sv
// Shared widths and writeback source encoding for the regfile write scheduler.
// No logic here.
// Constants only.
package rf_wb_sched_pkg;
    localparam int XLEN = 32;
    localparam int RA_W = 4;
    localparam int NREG = 2 ** RA_W;

    typedef enum logic {
        SRC_ALU = 1'b0,
        SRC_LD  = 1'b1
    } wb_src_e;
endpackage

// File: rtl/rf_wb_sched_wb_rr_arb.sv
// Two-way round-robin arbiter for the ALU and load writeback streams.
// Latency: grant is combinational from the valids; only the pointer is registered.
// Backpressure: the loser of a contested cycle keeps requesting and wins the next one.
module wb_rr_arb
    import rf_wb_sched_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    output logic [1:0] gnt,
    output wb_src_e    sel
);

    wb_src_e rr_ptr;

    always_comb begin
        sel = SRC_ALU;
        gnt = 2'b00;
        if (rst_n) begin
            if (req[0] && req[1]) begin
                sel = rr_ptr;
            end else if (req[1]) begin
                sel = SRC_LD;
            end
            if (req != 2'b00) begin
                gnt = (sel == SRC_LD) ? 2'b10 : 2'b01;
            end
        end
    end

    // The pointer only moves when both sources competed.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_ptr <= SRC_ALU;
        end else if (req == 2'b11) begin
            rr_ptr <= (rr_ptr == SRC_ALU) ? SRC_LD : SRC_ALU;
        end
    end

endmodule

// File: rtl/rf_wb_sched.sv
// Issue scoreboard (RAW/WAW stall) and writeback arbitration onto the single regfile write port.
// Latency: one cycle from a writeback grant to rf_we; busy updates one cycle after issue/writeback.
// Backpressure: iss_ready drops on a hazard; alu_ready/ld_ready follow the round-robin grant.
module rf_wb_sched #(
    parameter int XLEN = rf_wb_sched_pkg::XLEN,
    parameter int RA_W = rf_wb_sched_pkg::RA_W
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 iss_valid,
    output logic                 iss_ready,
    input  logic [RA_W-1:0]      iss_rs1,
    input  logic [RA_W-1:0]      iss_rs2,
    input  logic                 iss_use_rs1,
    input  logic                 iss_use_rs2,
    input  logic [RA_W-1:0]      iss_rd,
    input  logic                 iss_wr,
    input  logic                 alu_valid,
    output logic                 alu_ready,
    input  logic [RA_W-1:0]      alu_rd,
    input  logic [XLEN-1:0]      alu_data,
    input  logic                 ld_valid,
    output logic                 ld_ready,
    input  logic [RA_W-1:0]      ld_rd,
    input  logic [XLEN-1:0]      ld_data,
    output logic                 rf_we,
    output logic [RA_W-1:0]      rf_rd,
    output logic [XLEN-1:0]      rf_wdata,
    output logic [2**RA_W-1:0]   busy,
    output logic                 wb_err
);
    import rf_wb_sched_pkg::*;

    typedef struct packed {
        logic [RA_W-1:0] rd;
        logic [XLEN-1:0] dat;
    } wb_req_t;

    logic [1:0]          wb_gnt;
    wb_src_e             wb_sel;
    wb_req_t             wb_in;
    logic                wb_xfer;
    logic                wb_nz;
    logic                iss_xfer;
    logic                haz;
    logic [2**RA_W-1:0]  busy_nxt;

    wb_rr_arb u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .req   ({ld_valid, alu_valid}),
        .gnt   (wb_gnt),
        .sel   (wb_sel)
    );

    assign alu_ready = wb_gnt[0];
    assign ld_ready  = wb_gnt[1];
    assign wb_xfer   = wb_gnt[0] | wb_gnt[1];

    always_comb begin
        wb_in.rd  = alu_rd;
        wb_in.dat = alu_data;
        if (wb_sel == SRC_LD) begin
            wb_in.rd  = ld_rd;
            wb_in.dat = ld_data;
        end
    end

    assign wb_nz = (wb_in.rd != '0);

    // Hazard uses pre-clear busy: no bypass from a same-cycle writeback.
    assign haz = (iss_use_rs1 && (iss_rs1 != '0) && busy[iss_rs1])
               | (iss_use_rs2 && (iss_rs2 != '0) && busy[iss_rs2])
               | (iss_wr      && (iss_rd  != '0) && busy[iss_rd]);

    assign iss_ready = rst_n & ~haz;
    assign iss_xfer  = iss_valid & iss_ready;

    // Set after clear so a new owner of the same index wins.
    always_comb begin
        busy_nxt = busy;
        if (wb_xfer && wb_nz) begin
            busy_nxt[wb_in.rd] = 1'b0;
        end
        if (iss_xfer && iss_wr && (iss_rd != '0)) begin
            busy_nxt[iss_rd] = 1'b1;
        end
        busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy     <= '0;
            rf_we    <= 1'b0;
            rf_rd    <= '0;
            rf_wdata <= '0;
            wb_err   <= 1'b0;
        end else begin
            busy  <= busy_nxt;
            rf_we <= wb_xfer && wb_nz;
            if (wb_xfer) begin
                rf_rd    <= wb_in.rd;
                rf_wdata <= wb_in.dat;
            end
            if (wb_xfer && wb_nz && !busy[wb_in.rd]) begin
                wb_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_rf_wb_sched.sv
// Scoreboarded random + directed bench for rf_wb_sched against a register-set reference model.
module tb_rf_wb_sched;

    logic        clk;
    logic        rst_n;
    logic        iss_valid, iss_ready;
    logic [3:0]  iss_rs1, iss_rs2, iss_rd;
    logic        iss_use_rs1, iss_use_rs2, iss_wr;
    logic        alu_valid, alu_ready;
    logic [3:0]  alu_rd;
    logic [31:0] alu_data;
    logic        ld_valid, ld_ready;
    logic [3:0]  ld_rd;
    logic [31:0] ld_data;
    logic        rf_we;
    logic [3:0]  rf_rd;
    logic [31:0] rf_wdata;
    logic [15:0] busy;
    logic        wb_err;

    rf_wb_sched dut (
        .clk(clk), .rst_n(rst_n),
        .iss_valid(iss_valid), .iss_ready(iss_ready),
        .iss_rs1(iss_rs1), .iss_rs2(iss_rs2),
        .iss_use_rs1(iss_use_rs1), .iss_use_rs2(iss_use_rs2),
        .iss_rd(iss_rd), .iss_wr(iss_wr),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_rd(ld_rd), .ld_data(ld_data),
        .rf_we(rf_we), .rf_rd(rf_rd), .rf_wdata(rf_wdata),
        .busy(busy), .wb_err(wb_err)
    );

    typedef struct {
        logic [3:0]  rd;
        logic [31:0] dat;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference state: the set of pending destinations, sticky error, and whose turn it is.
    bit   m_pend [16];
    bit   m_err;
    bit   m_ld_turn;
    bit   last_ga, last_gl;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] m_busy_vec();
        logic [15:0] v;
        v = '0;
        for (int i = 1; i < 16; i++) v[i] = m_pend[i];
        return v;
    endfunction

    function automatic logic [3:0] pick_rd();
        int cand[$];
        for (int i = 1; i < 16; i++) if (m_pend[i]) cand.push_back(i);
        if (cand.size() == 0 || $urandom_range(7) == 0) return 4'($urandom_range(15));
        return 4'(cand[$urandom_range(cand.size() - 1)]);
    endfunction

    task automatic idle_inputs();
        iss_valid = 0; iss_rs1 = 0; iss_rs2 = 0; iss_use_rs1 = 0; iss_use_rs2 = 0;
        iss_rd = 0; iss_wr = 0;
        alu_valid = 0; alu_rd = 0; alu_data = 0;
        ld_valid = 0; ld_rd = 0; ld_data = 0;
    endtask

    // Compare combinational outputs with the model, advance the model across one clock edge.
    task automatic step();
        bit   haz, exp_rdy, ga, gl;
        bit   nxt [16];
        logic [3:0]  g_rd;
        logic [31:0] g_dat;
        exp_t e;
        #1;
        chk("busy", busy, m_busy_vec());
        chk("wb_err", wb_err, m_err);
        haz = (iss_use_rs1 && iss_rs1 != 0 && m_pend[iss_rs1])
           || (iss_use_rs2 && iss_rs2 != 0 && m_pend[iss_rs2])
           || (iss_wr && iss_rd != 0 && m_pend[iss_rd]);
        exp_rdy = rst_n && !haz;
        ga = 0; gl = 0;
        if (rst_n) begin
            if (alu_valid && ld_valid) begin
                gl = m_ld_turn;
                ga = !m_ld_turn;
            end else begin
                ga = alu_valid;
                gl = ld_valid;
            end
        end
        chk("iss_ready", iss_ready, exp_rdy);
        chk("alu_ready", alu_ready, ga);
        chk("ld_ready", ld_ready, gl);
        nxt = m_pend;
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) nxt[i] = 0;
            m_err = 0;
            m_ld_turn = 0;
        end else begin
            if (ga || gl) begin
                g_rd  = ga ? alu_rd : ld_rd;
                g_dat = ga ? alu_data : ld_data;
                if (g_rd != 0) begin
                    if (!m_pend[g_rd]) m_err = 1;
                    e.rd = g_rd;
                    e.dat = g_dat;
                    exp_q.push_back(e);
                    nxt[g_rd] = 0;
                end
                if (alu_valid && ld_valid) m_ld_turn = !m_ld_turn;
            end
            if (iss_valid && exp_rdy && iss_wr && iss_rd != 0) nxt[iss_rd] = 1;
        end
        last_ga = ga;
        last_gl = gl;
        @(posedge clk);
        m_pend = nxt;
        @(negedge clk);
    endtask

    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (rf_we === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL wb_unexpected actual rd=%0h data=%0h required no write", rf_rd, rf_wdata);
                end else begin
                    e = exp_q.pop_front();
                    chk("wb_rd", rf_rd, e.rd);
                    chk("wb_data", rf_wdata, e.dat);
                end
            end else if (exp_q.size() != 0) begin
                checks++;
                errors++;
                $display("FAIL wb_missing actual rf_we=%b required rd=%0h", rf_we, exp_q[0].rd);
                exp_q.delete();
            end
        end
    end

    initial begin
        idle_inputs();
        rst_n = 0;
        m_err = 0; m_ld_turn = 0;
        for (int i = 0; i < 16; i++) m_pend[i] = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1 chk("ready_in_reset", iss_ready, 0);
        rst_n = 1;

        // reset then idle
        chk("rst_busy", busy, 0);
        chk("rst_we", rf_we, 0);
        iss_rs1 = 4'd6; iss_use_rs1 = 1; iss_rd = 4'd2; iss_wr = 1;
        #1 chk("idle_ready", iss_ready, 1);
        idle_inputs();
        step();

        // RAW stall on x3
        iss_valid = 1; iss_wr = 1; iss_rd = 4'd3;
        step();
        iss_wr = 0; iss_rd = 0; iss_use_rs1 = 1; iss_rs1 = 4'd3;
        #1 chk("raw_stall", iss_ready, 0);
        alu_valid = 1; alu_rd = 4'd3; alu_data = 32'hDEADBEEF;
        #1 chk("raw_stall_wb", iss_ready, 0);
        step();
        alu_valid = 0;
        chk("raw_we", rf_we, 1);
        chk("raw_rd", rf_rd, 3);
        chk("raw_data", rf_wdata, 32'hDEADBEEF);
        chk("raw_busy3", busy[3], 0);
        #1 chk("raw_release", iss_ready, 1);
        step();
        idle_inputs();

        // contention: x4 and x5 pending, both sources request
        iss_valid = 1; iss_wr = 1; iss_rd = 4'd4;
        step();
        iss_rd = 4'd5;
        step();
        idle_inputs();
        alu_valid = 1; alu_rd = 4'd4; alu_data = 32'h4444_0004;
        ld_valid = 1; ld_rd = 4'd5; ld_data = 32'h5555_0005;
        #1 chk("cont_alu_first", alu_ready, 1);
        chk("cont_ld_wait", ld_ready, 0);
        step();
        alu_valid = 0;
        chk("cont_rd1", rf_rd, 4);
        #1 chk("cont_ld_second", ld_ready, 1);
        step();
        ld_valid = 0;
        chk("cont_rd2", rf_rd, 5);

        // x0 handling
        iss_valid = 1; iss_wr = 1; iss_rd = 4'd0;
        #1 chk("x0_iss_ready", iss_ready, 1);
        step();
        chk("x0_busy", busy, 0);
        idle_inputs();
        ld_valid = 1; ld_rd = 4'd0; ld_data = 32'h1234;
        #1 chk("x0_ld_ready", ld_ready, 1);
        step();
        ld_valid = 0;
        chk("x0_we", rf_we, 0);
        chk("x0_err", wb_err, 0);

        // same-cycle clear of x7 and WAW retry
        iss_valid = 1; iss_wr = 1; iss_rd = 4'd7;
        step();
        alu_valid = 1; alu_rd = 4'd7; alu_data = 32'h7777;
        #1 chk("waw_stall", iss_ready, 0);
        step();
        alu_valid = 0;
        #1 chk("waw_retry", iss_ready, 1);
        step();
        idle_inputs();
        chk("waw_busy7", busy[7], 1);

        // spurious writeback then mid-run reset
        alu_valid = 1; alu_rd = 4'd9; alu_data = 32'h9999;
        step();
        alu_valid = 0;
        chk("spur_err", wb_err, 1);
        alu_valid = 1; alu_rd = 4'd7; alu_data = 32'h7070;
        step();
        alu_valid = 0;
        chk("spur_err_sticky", wb_err, 1);
        iss_valid = 1; iss_wr = 1; iss_rd = 4'd8;
        rst_n = 0;
        step();
        rst_n = 1;
        idle_inputs();
        chk("rst2_err", wb_err, 0);
        chk("rst2_busy", busy, 0);
        chk("rst2_we", rf_we, 0);

        // random traffic
        for (int it = 0; it < 3000; it++) begin
            if ($urandom_range(255) == 0) begin
                rst_n = 0;
                idle_inputs();
            end else begin
                rst_n = 1;
                if (!alu_valid || last_ga) begin
                    alu_valid = ($urandom_range(2) != 0);
                    alu_rd = pick_rd();
                    alu_data = $urandom;
                end
                if (!ld_valid || last_gl) begin
                    ld_valid = ($urandom_range(2) != 0);
                    ld_rd = pick_rd();
                    ld_data = $urandom;
                end
                iss_valid   = $urandom_range(1);
                iss_rs1     = 4'($urandom_range(15));
                iss_rs2     = 4'($urandom_range(15));
                iss_use_rs1 = $urandom_range(1);
                iss_use_rs2 = $urandom_range(1);
                iss_rd      = 4'($urandom_range(15));
                iss_wr      = ($urandom_range(3) != 0);
            end
            step();
        end
        idle_inputs();
        step();
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
